// File: rtl/dpd_mag_addr_gen.sv
// DPD LUT address generator: two IQ samples per clock in, per-sample |x|^2 scaled,
// saturated into a LUT address, with IQ delayed to stay aligned. Fixed 4-cycle latency.

module dpd_mag_lane #(
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int SW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          vld_i,
    input  logic [DW-1:0] x_i,
    input  logic [SW-1:0] shift_i,
    output logic [DW-1:0] x_o,
    output logic [AW-1:0] addr_o,
    output logic          sat_o
);
    localparam int HW = DW / 2;

    logic [DW-1:0]        x1_q, x2_q, x3_q, x4_q;
    logic [DW-1:0]        sqi_q, sqq_q, p_q;
    logic [DW-1:0]        sqi_d, sqq_d, q_s4;
    logic [AW-1:0]        addr_q, addr_d;
    logic signed [DW-1:0] i_x, q_x;

    // Sign-extend to full width so the low DW bits of the product are the exact square.
    assign i_x   = $signed({{HW{x1_q[DW-1]}}, x1_q[DW-1:HW]});
    assign q_x   = $signed({{HW{x1_q[HW-1]}}, x1_q[HW-1:0]});
    assign sqi_d = i_x * i_x;
    assign sqq_d = q_x * q_x;

    assign q_s4   = p_q >> shift_i;
    assign sat_o  = |q_s4[DW-1:AW];
    assign addr_d = sat_o ? {AW{1'b1}} : q_s4[AW-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x1_q   <= '0;
            x2_q   <= '0;
            x3_q   <= '0;
            x4_q   <= '0;
            sqi_q  <= '0;
            sqq_q  <= '0;
            p_q    <= '0;
            addr_q <= '0;
        end else begin
            x1_q   <= vld_i ? x_i : '0;
            x2_q   <= x1_q;
            x3_q   <= x2_q;
            x4_q   <= x3_q;
            sqi_q  <= sqi_d;
            sqq_q  <= sqq_d;
            p_q    <= sqi_q + sqq_q;
            addr_q <= addr_d;
        end
    end

    assign x_o    = x4_q;
    assign addr_o = addr_q;
endmodule

module dpd_mag_addr_gen #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int SHIFT_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    din_valid_i,
    input  logic [2*DATA_WIDTH-1:0] din_i,
    input  logic [SHIFT_WIDTH-1:0]  cfg_shift_i,
    input  logic                    cfg_load_i,
    input  logic                    sat_clr_i,
    output logic [2*DATA_WIDTH-1:0] dout_o,
    output logic [2*ADDR_WIDTH-1:0] mag_o,
    output logic                    dout_valid_o,
    output logic [CNT_WIDTH-1:0]    sat_cnt_o
);
    localparam int NUM_LANES = 2;
    localparam int STAGES    = 4;
    localparam int NW        = $clog2(NUM_LANES + 1);

    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_din, lane_dout;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
    logic [NUM_LANES-1:0]                 lane_sat;
    logic [SHIFT_WIDTH-1:0]               shift_q;
    logic [STAGES-1:0]                    vld_q;
    logic [STAGES:0]                      vld_pipe;
    logic [CNT_WIDTH-1:0]                 cnt_q, cnt_d;
    logic [CNT_WIDTH:0]                   cnt_sum;
    logic [NW-1:0]                        nsat;

    assign lane_din = din_i;
    assign vld_pipe = {vld_q, din_valid_i};

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            dpd_mag_lane #(
                .DW(DATA_WIDTH),
                .AW(ADDR_WIDTH),
                .SW(SHIFT_WIDTH)
            ) u_lane (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .vld_i  (din_valid_i),
                .x_i    (lane_din[l]),
                .shift_i(shift_q),
                .x_o    (lane_dout[l]),
                .addr_o (lane_addr[l]),
                .sat_o  (lane_sat[l])
            );
        end
    endgenerate

    // Saturations are counted on the edge that registers S4, so sat_cnt moves with dout.
    always_comb begin
        nsat = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            nsat = nsat + NW'(lane_sat[l] & vld_pipe[STAGES-1]);
        end
        cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(nsat);
        if (sat_clr_i)           cnt_d = '0;
        else if (cnt_sum[CNT_WIDTH]) cnt_d = '1;
        else                     cnt_d = cnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            vld_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (cfg_load_i) shift_q <= cfg_shift_i;
            vld_q <= vld_pipe[STAGES-1:0];
            cnt_q <= cnt_d;
        end
    end

    assign dout_o       = lane_dout;
    assign mag_o        = lane_addr;
    assign dout_valid_o = vld_pipe[STAGES];
    assign sat_cnt_o    = cnt_q;
endmodule
